// File: rtl/key_pad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Covers state encoding, line idle/reset patterns and the low-bit index helper.
package key_pad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  localparam logic [3:0] COL_IDLE  = 4'b1111;
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Index of the lowest zero bit; the lowest row wins when several are low.
  function automatic logic [1:0] low_index(input logic [3:0] lines);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!lines[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_pad_tick.sv
// Free-running millisecond divider.
// Emits a one-cycle tick each time the counter reaches T1ms-1.
module key_pad_tick #(
  parameter int T1ms = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (T1ms > 2) ? $clog2(T1ms) : 1;
  localparam logic [CW-1:0] LAST = CW'(T1ms - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/key_pad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce.
// Drives one column low at a time and reports each confirmed press once.
module key_pad_scanner
  import key_pad_pkg::*;
#(
  parameter int T1ms    = 50_000,
  parameter int NUM_KEY = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] data,
  output logic       flag
);

  localparam int DW = $clog2(NUM_KEY + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(NUM_KEY - 1);

  state_t          state, state_next;
  logic [3:0]      row_meta, rs;
  logic [3:0]      cand, cand_next;
  logic [3:0]      col_next, data_next;
  logic [DW-1:0]   db_cnt, db_cnt_next;
  logic            flag_next;
  logic            tick;

  key_pad_tick #(.T1ms(T1ms)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= COL_IDLE;
      rs       <= COL_IDLE;
      state    <= SCAN;
      col      <= COL_RESET;
      cand     <= COL_IDLE;
      db_cnt   <= '0;
      data     <= 4'h0;
      flag     <= 1'b0;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
      state    <= state_next;
      col      <= col_next;
      cand     <= cand_next;
      db_cnt   <= db_cnt_next;
      data     <= data_next;
      flag     <= flag_next;
    end
  end

  // The debounce counter only advances on ticks, so NUM_KEY ticks of a stable
  // candidate confirm a press; the release path reuses the same counter.
  always_comb begin
    state_next  = state;
    col_next    = col;
    cand_next   = cand;
    db_cnt_next = db_cnt;
    data_next   = data;
    flag_next   = 1'b0;
    case (state)
      SCAN: begin
        if (rs == COL_IDLE) begin
          if (tick) col_next = {col[2:0], col[3]};
        end else begin
          cand_next   = rs;
          db_cnt_next = '0;
          state_next  = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (rs == COL_IDLE) begin
          state_next = SCAN;
        end else if (rs != cand) begin
          cand_next   = rs;
          db_cnt_next = '0;
        end else if (tick) begin
          if (db_cnt == DB_LAST) begin
            data_next  = {low_index(cand), low_index(col)};
            flag_next  = 1'b1;
            state_next = HELD;
          end else begin
            db_cnt_next = db_cnt + 1'b1;
          end
        end
      end
      HELD: begin
        if (rs == COL_IDLE) begin
          db_cnt_next = '0;
          state_next  = REL_DB;
        end
      end
      REL_DB: begin
        if (rs != COL_IDLE) begin
          state_next = HELD;
        end else if (tick) begin
          if (db_cnt == DB_LAST) begin
            state_next = SCAN;
          end else begin
            db_cnt_next = db_cnt + 1'b1;
          end
        end
      end
      default: state_next = SCAN;
    endcase
  end

endmodule

// File: tb/tb_key_pad_scanner.sv
// Directed bench for key_pad_scanner with a behavioural keypad model.
// One millisecond tick is shortened to 50 clocks, so "us" below means one tick.
module tb_key_pad_scanner;

  localparam int T1MS = 50;
  localparam int NKEY = 20;
  localparam int CPT  = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] data;
  logic       flag;

  logic       pressed = 1'b0;
  logic [3:0] key = 4'h0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int flag_rises = 0;
  int flag_cycles = 0;
  int last_flag_cyc = 0;
  logic flag_q = 1'b0;
  logic [3:0] flag_log[$];

  key_pad_scanner #(.T1ms(T1MS), .NUM_KEY(NKEY)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .row  (row),
    .col  (col),
    .data (data),
    .flag (flag)
  );

  always #10 clk = ~clk;

  // Keypad model: the pressed key shorts its row to its column line.
  always_comb begin
    row = 4'hF;
    if (pressed) row[key[3:2]] = col[key[1:0]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (flag) begin
      flag_cycles++;
      if (!flag_q) begin
        flag_rises++;
        flag_log.push_back(data);
        last_flag_cyc = cyc;
      end
    end
    flag_q = flag;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_ticks(input int n);
    repeat (n * CPT) @(negedge clk);
  endtask

  function automatic logic [3:0] last_logged();
    if (flag_log.size() == 0) return 4'hx;
    return flag_log[flag_log.size() - 1];
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    pressed = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (col !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL reset_col: got %b expected %b", col, 4'b1110);
    end
    checks++;
    if (data !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected %h", data, 4'h0);
    end
    checks++;
    if (flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flag: got %b expected %b", flag, 1'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [3:0] prev;
    logic [3:0] exp_col;
    int n;
    prev = col;
    n = 0;
    while (col === prev && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (col !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL scan_first: got %b expected %b", col, 4'b1101);
    end
    exp_col = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      exp_col = {exp_col[2:0], exp_col[3]};
      prev = col;
      n = 0;
      while (col === prev && n < 60) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != CPT || col !== exp_col) begin
        errors++;
        $display("[TB] FAIL scan_step%0d: got col=%b after %0d clk expected col=%b after %0d clk",
                 i, col, n, exp_col, CPT);
      end
    end
    checks++;
    if (flag_rises != 0 || data !== 4'h0) begin
      errors++;
      $display("[TB] FAIL idle_quiet: got flags=%0d data=%h expected flags=0 data=0",
               flag_rises, data);
    end
  endtask

  task automatic test_single_key();
    int r0;
    logic [3:0] prev;
    int n;
    r0 = flag_rises;
    key = 4'h9;
    pressed = 1'b1;
    wait_ticks(25);
    checks++;
    if (flag_rises - r0 != 1) begin
      errors++;
      $display("[TB] FAIL key9_count: got %0d flags expected 1", flag_rises - r0);
    end
    checks++;
    if (last_logged() !== 4'h9 || data !== 4'h9) begin
      errors++;
      $display("[TB] FAIL key9_data: got flag_data=%h data=%h expected 9", last_logged(), data);
    end
    pressed = 1'b0;
    wait_ticks(50);
    checks++;
    if (flag_rises - r0 != 1) begin
      errors++;
      $display("[TB] FAIL key9_no_repeat: got %0d flags expected 1", flag_rises - r0);
    end
    prev = col;
    n = 0;
    while (col === prev && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (col === prev) begin
      errors++;
      $display("[TB] FAIL key9_rescan: got col stuck at %b expected rotation", col);
    end
  endtask

  task automatic test_bounce();
    int r0;
    int edge_cyc;
    int lat;
    r0 = flag_rises;
    edge_cyc = 0;
    key = 4'h0;
    for (int i = 0; i < 5; i++) begin
      pressed = (i % 2 == 0);
      if (i == 4) edge_cyc = cyc;
      wait_ticks(3);
    end
    wait_ticks(25);
    lat = last_flag_cyc - edge_cyc;
    checks++;
    if (flag_rises - r0 != 1) begin
      errors++;
      $display("[TB] FAIL bounce_count: got %0d flags expected 1", flag_rises - r0);
    end
    checks++;
    if (last_logged() !== 4'h0) begin
      errors++;
      $display("[TB] FAIL bounce_data: got %h expected %h", last_logged(), 4'h0);
    end
    checks++;
    if (lat < 19 * CPT || lat > 25 * CPT) begin
      errors++;
      $display("[TB] FAIL bounce_latency: got %0d clk expected %0d..%0d clk",
               lat, 19 * CPT, 25 * CPT);
    end
    pressed = 1'b0;
    wait_ticks(50);
  endtask

  task automatic test_back_to_back();
    int r0;
    int w0;
    int n;
    r0 = flag_rises;
    w0 = flag_cycles;
    key = 4'hA;
    pressed = 1'b1;
    wait_ticks(30);
    pressed = 1'b0;
    wait_ticks(50);
    key = 4'hB;
    pressed = 1'b1;
    wait_ticks(45);
    pressed = 1'b0;
    wait_ticks(50);
    checks++;
    if (flag_rises - r0 != 2) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d flags expected 2", flag_rises - r0);
    end
    checks++;
    if (flag_cycles - w0 != 2) begin
      errors++;
      $display("[TB] FAIL b2b_width: got %0d flag cycles expected 2", flag_cycles - w0);
    end
    n = flag_log.size();
    checks++;
    if (n < 2 || flag_log[n - 2] !== 4'hA || flag_log[n - 1] !== 4'hB) begin
      errors++;
      $display("[TB] FAIL b2b_order: got %h,%h expected a,b",
               (n >= 2) ? flag_log[n - 2] : 4'hx, last_logged());
    end
  endtask

  task automatic test_glitch();
    int r0;
    r0 = flag_rises;
    key = 4'h5;
    pressed = 1'b1;
    wait_ticks(10);
    pressed = 1'b0;
    wait_ticks(30);
    checks++;
    if (flag_rises - r0 != 0) begin
      errors++;
      $display("[TB] FAIL glitch_count: got %0d flags expected 0", flag_rises - r0);
    end
    checks++;
    if (data !== 4'hB) begin
      errors++;
      $display("[TB] FAIL glitch_data: got %h expected %h", data, 4'hB);
    end
  endtask

  task automatic test_reset_mid_press();
    int r0;
    key = 4'h6;
    pressed = 1'b1;
    wait_ticks(8);
    r0 = flag_rises;
    rst_n = 1'b0;
    #1;
    checks++;
    if (col !== 4'b1110 || flag !== 1'b0 || data !== 4'h0) begin
      errors++;
      $display("[TB] FAIL midreset_state: got col=%b flag=%b data=%h expected col=1110 flag=0 data=0",
               col, flag, data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(15);
    checks++;
    if (flag_rises - r0 != 0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: got %0d flags expected 0", flag_rises - r0);
    end
    wait_ticks(12);
    checks++;
    if (flag_rises - r0 != 1 || data !== 4'h6) begin
      errors++;
      $display("[TB] FAIL midreset_fresh: got flags=%0d data=%h expected flags=1 data=6",
               flag_rises - r0, data);
    end
    pressed = 1'b0;
    wait_ticks(30);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_bounce();
    test_back_to_back();
    test_glitch();
    test_reset_mid_press();
    checks++;
    if (flag_cycles != flag_rises) begin
      errors++;
      $display("[TB] FAIL flag_width: got %0d high cycles expected %0d", flag_cycles, flag_rises);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_pad_scanner.md
Name: key_pad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad by driving one column low at a time and sampling the four row lines.
- Debounces each press and release over a configurable number of millisecond ticks.
- On a confirmed press, outputs a 4-bit key code and a one-cycle valid strobe.
- Sits between the board keypad pins and downstream consumers such as display or command logic.

Parameters:
- T1ms, 50_000, clock cycles per 1 ms tick (50 MHz clock); must be >= 2.
- NUM_KEY, 20, debounce length in ms ticks for both press and release; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- row  input  4  keypad row lines; low = a key in that row connects to a low column. Sampled after a 2-flop synchronizer.
- col  output  4  column drive; exactly one bit low during scanning.
- data  output  4  last confirmed key code.
- flag  output  1  one-cycle pulse when data is updated.

Behaviour:
- Clock/reset: single clk domain; reset is asynchronous, active-low (rst_n).
- Reset values: col=4'b1110, data=0, flag=0, tick counter=0, debounce counter=0, state=SCAN.
- Tick: free-running counter 0..T1ms-1; tick asserts for one cycle when the counter equals T1ms-1, then the counter wraps to 0.
- Key code: data = 4*r + c.
  - r = index of the low row bit; row[0] maps to codes 0-3, row[3] to codes 12-15.
  - c = index of the low col bit.
- Multiple rows low: the lowest index wins.
- State machine, all row decisions use the synchronized row value (rs):
  - SCAN:
    - If rs==4'b1111, rotate col on each tick: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    - If rs!=4'b1111, freeze col, capture rs as the candidate, clear the debounce counter, and go to PRESS_DB.
  - PRESS_DB:
    - rs==1111 returns to SCAN and resumes rotation from the current col.
    - rs different from the candidate (but not 1111): recapture the candidate and clear the counter.
    - Otherwise, increment the counter on each tick.
    - When the counter reaches NUM_KEY: latch data from the candidate and the current col, pulse flag for exactly one clk, and go to HELD.
  - HELD:
    - col stays frozen.
    - When rs==1111, clear the counter and go to REL_DB.
  - REL_DB:
    - rs!=1111 returns to HELD with no new flag.
    - Otherwise, count ticks; at NUM_KEY go to SCAN.
- Holding a key never repeats flag. A press shorter than NUM_KEY ticks yields no flag, and data is unchanged.
- Reset mid-operation: all state is cleared immediately; no flag is issued during or after reset until a new full debounce completes.
- Latency: a press is reported NUM_KEY ticks (±1 tick) after the scan reaches its column, plus 2 clk of synchronizer delay.

Decomposition:
- Package key_pad_pkg holds:
  - the state encoding (SCAN, PRESS_DB, HELD, REL_DB);
  - the column idle constant 4'b1111;
  - the reset column constant 4'b1110.
- One natural sub-module: key_pad_tick, the T1ms divider producing the one-cycle tick.
- Scanner FSM, debounce counter and code encoder stay in the top level.

Test Plan:
- Use T1ms=50 and NUM_KEY=20 with a 20 ns clock in all scenarios. The bench models the keypad by setting row bit r = col[c] for the pressed key, else 1.
- Reset with no key: col rotates 1110, 1101, 1011, 0111 every 50 clk; flag stays 0; data=0.
- Key 0x9 (row[2] tied to col[1]) held 25 us, then released 50 us: exactly one flag pulse with data=4'h9; scanning resumes after release debounce.
- Key 0xA held 30 us, then key 0xB held 45 us, each followed by 50 us release: exactly two flags, data=4'hA then 4'hB, each flag 1 clk wide.
- Glitch: key 0x5 held 10 us (< 20 ticks), then released: no flag, data keeps its previous value.
- Bounce: key 0x0 toggles every 3 us for 15 us, then holds steady 25 us: single flag with data=4'h0, issued 20 ticks after the last bounce.
- Reset asserted during PRESS_DB: col=1110, flag=0, data=0 immediately; no flag until a fresh full press.
